// File: rtl/sti_writer_if.sv
// Pixel stream in, sti memory write port out.
// The slave modport is the sti_writer side; master is the pixel source / memory side.
interface sti_writer_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic        sti_wr;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_last,
        input  pix_ready,
        input  sti_wr,
        input  sti_addr,
        input  sti_do
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        output pix_ready,
        output sti_wr,
        output sti_addr,
        output sti_do
    );
endinterface

// File: rtl/sti_writer.sv
// sti_writer: thresholds a raster pixel stream to 1 bit per pixel, packs 16
// pixels per word (earliest pixel in bit 15) and writes the words in address
// order into the sti memory. Raises done when the whole frame is written and
// err when pix_last does not coincide with the final counted pixel.
module sti_writer #(
    parameter logic [7:0] THRESH  = 8'd0,
    parameter int         N_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    sti_writer_if.slave bus,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Index of the final pixel of a frame; the frame ends on this count, not on pix_last.
    localparam logic [13:0] LAST_PIX = 14'(16 * N_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic [14:0] shreg_q, shreg_d;
    logic        wr_q, wr_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] do_q, do_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        pix_bit;
    logic        last_pix;

    function automatic logic threshold_bit(input logic [7:0] pix);
        return (pix > THRESH);
    endfunction

    assign bus.pix_ready = (state_q == S_RUN);
    assign bus.sti_wr    = wr_q;
    assign bus.sti_addr  = addr_q;
    assign bus.sti_do    = do_q;
    assign done          = done_q;
    assign err           = err_q;

    // Next-state, packing and write-strobe generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        do_d     = do_q;
        done_d   = done_q;
        err_d    = err_q;

        accept   = bus.pix_valid && (state_q == S_RUN);
        pix_bit  = threshold_bit(bus.pix_data);
        last_pix = (cnt_q == LAST_PIX);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    done_d = 1'b1;
                end
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    shreg_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    shreg_d = {shreg_q[13:0], pix_bit};
                    cnt_d   = cnt_q + 14'd1;
                    // The 16th pixel of a word completes it; issue the write on this edge.
                    if (cnt_q[3:0] == 4'hF) begin
                        wr_d   = 1'b1;
                        do_d   = {shreg_q, pix_bit};
                        addr_d = cnt_q[13:4];
                    end
                    if ((bus.pix_last && !last_pix) || (last_pix && !bus.pix_last)) begin
                        err_d = 1'b1;
                    end
                    if (last_pix) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // The final word's write strobe is high during this cycle.
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            do_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            do_q    <= do_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sti_writer.sv
// Bench for sti_writer. Two instances: dut0 is the full 1024-word frame with
// THRESH=0; dut1 is a 16-word frame with THRESH=127 used for threshold, error
// and mid-frame reset scenarios. Expected words are queued as pixels are
// accepted and compared when the DUT strobes sti_wr.
`timescale 1ns/1ps
module tb_sti_writer;

    typedef struct packed {
        logic        sel;
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  start_v;
    logic [1:0]  valid_v;
    logic [1:0]  last_v;
    logic [7:0]  data_v [2];

    logic [1:0]  rdy_w, wr_w, done_w, err_w;
    logic [9:0]  addr_w [2];
    logic [15:0] do_w [2];

    int          errors;
    int          checks;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] img [2][1024];
    logic [15:0] ref_img [1024];
    int          wr_cnt [2];
    int          npix [2];
    logic [7:0]  thr [2];

    logic [14:0] m_bits;
    int          m_cnt;
    logic        m_err;

    sti_writer_if bus0 ();
    sti_writer_if bus1 ();

    assign bus0.pix_valid = valid_v[0];
    assign bus0.pix_data  = data_v[0];
    assign bus0.pix_last  = last_v[0];
    assign bus1.pix_valid = valid_v[1];
    assign bus1.pix_data  = data_v[1];
    assign bus1.pix_last  = last_v[1];

    assign rdy_w  = {bus1.pix_ready, bus0.pix_ready};
    assign wr_w   = {bus1.sti_wr, bus0.sti_wr};
    assign addr_w[0] = bus0.sti_addr;
    assign addr_w[1] = bus1.sti_addr;
    assign do_w[0]   = bus0.sti_do;
    assign do_w[1]   = bus1.sti_do;

    sti_writer #(.THRESH(8'd0), .N_WORDS(1024)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .start (start_v[0]),
        .bus   (bus0),
        .done  (done_w[0]),
        .err   (err_w[0])
    );

    sti_writer #(.THRESH(8'd127), .N_WORDS(16)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start_v[1]),
        .bus   (bus1),
        .done  (done_w[1]),
        .err   (err_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: every strobe must match the next queued word.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (wr_w[s] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected dut%0d: got write addr=%0d data=%h, expected no write",
                             s, addr_w[s], do_w[s]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.sel !== s[0] || mon_e.addr !== addr_w[s] || mon_e.data !== do_w[s]) begin
                        errors++;
                        $display("FAIL wr_word dut%0d: got addr=%0d data=%h, expected dut%0d addr=%0d data=%h",
                                 s, addr_w[s], do_w[s], mon_e.sel, mon_e.addr, mon_e.data);
                    end
                end
                img[s][addr_w[s]] = do_w[s];
                wr_cnt[s]++;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix_val(input int mode, input int i);
        case (mode)
            0:       return (i % 2 == 0) ? 8'hFF : 8'h00;
            1:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic start_frame(input int sel);
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        m_bits = '0;
        m_cnt = 0;
        m_err = 1'b0;
        wr_cnt[sel] = 0;
        checks++;
        if (rdy_w[sel] !== 1'b1 || done_w[sel] !== 1'b0 || err_w[sel] !== 1'b0) begin
            errors++;
            $display("FAIL start dut%0d: got ready=%b done=%b err=%b, expected ready=1 done=0 err=0",
                     sel, rdy_w[sel], done_w[sel], err_w[sel]);
        end
    endtask

    task automatic send_pixel(input int sel, input logic [7:0] d, input logic last, input int gap_pct);
        logic rdy;
        logic nb;
        bit   acc;
        exp_t e;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            valid_v[sel] = 1'b0;
            @(posedge clk); #1;
        end
        valid_v[sel] = 1'b1;
        data_v[sel]  = d;
        last_v[sel]  = last;
        acc = 1'b0;
        for (int t = 0; t < 8 && !acc; t++) begin
            rdy = rdy_w[sel];
            @(posedge clk); #1;
            if (rdy === 1'b1) acc = 1'b1;
        end
        valid_v[sel] = 1'b0;
        last_v[sel]  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL pix_accept dut%0d: pixel %0d not accepted in 8 cycles, expected ready=1", sel, m_cnt);
            return;
        end
        nb = (d > thr[sel]);
        if (m_cnt % 16 == 15) begin
            e.sel  = sel[0];
            e.addr = 10'(m_cnt / 16);
            e.data = {m_bits, nb};
            exp_q.push_back(e);
        end
        m_bits = {m_bits[13:0], nb};
        if (last && m_cnt != npix[sel] - 1) m_err = 1'b1;
        if (!last && m_cnt == npix[sel] - 1) m_err = 1'b1;
        m_cnt++;
    endtask

    // Streams pixels from index 'from' to the end of the frame, then checks completion timing.
    task automatic run_frame(input int sel, input int mode, input int gap_pct, input int last_at, input int from);
        for (int i = from; i < npix[sel]; i++) begin
            send_pixel(sel, pix_val(mode, i), (i == last_at), gap_pct);
        end
        checks++;
        if (rdy_w[sel] !== 1'b0 || done_w[sel] !== 1'b0 || wr_w[sel] !== 1'b1) begin
            errors++;
            $display("FAIL end_k dut%0d: got ready=%b done=%b wr=%b, expected ready=0 done=0 wr=1",
                     sel, rdy_w[sel], done_w[sel], wr_w[sel]);
        end
        @(posedge clk); #1;
        checks++;
        if (done_w[sel] !== 1'b0 || wr_w[sel] !== 1'b0) begin
            errors++;
            $display("FAIL end_k1 dut%0d: got done=%b wr=%b, expected done=0 wr=0", sel, done_w[sel], wr_w[sel]);
        end
        @(posedge clk); #1;
        checks++;
        if (done_w[sel] !== 1'b1 || err_w[sel] !== m_err) begin
            errors++;
            $display("FAIL end_k2 dut%0d: got done=%b err=%b, expected done=1 err=%b",
                     sel, done_w[sel], err_w[sel], m_err);
        end
        checks++;
        if (wr_cnt[sel] !== npix[sel] / 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL write_count dut%0d: got %0d writes (%0d pending), expected %0d writes",
                     sel, wr_cnt[sel], exp_q.size(), npix[sel] / 16);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (rdy_w[s] !== 1'b0 || wr_w[s] !== 1'b0 || addr_w[s] !== 10'd0 ||
                do_w[s] !== 16'd0 || done_w[s] !== 1'b0 || err_w[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got ready=%b wr=%b addr=%0d do=%h done=%b err=%b, expected all 0",
                         s, rdy_w[s], wr_w[s], addr_w[s], do_w[s], done_w[s], err_w[s]);
            end
        end
        reset = 1'b1;
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        checks++;
        if (rdy_w !== 2'b00) begin
            errors++;
            $display("FAIL idle_ready: got %b, expected 00", rdy_w);
        end
    endtask

    task automatic test_full_frame();
        start_frame(0);
        run_frame(0, 0, 0, 16383, 0);
        for (int a = 0; a < 1024; a++) ref_img[a] = img[0][a];
        checks++;
        if (err_w[0] !== 1'b0 || ref_img[517] !== 16'hAAAA) begin
            errors++;
            $display("FAIL full_frame: got err=%b word517=%h, expected err=0 word517=aaaa", err_w[0], ref_img[517]);
        end
    endtask

    task automatic test_restart_from_done();
        checks++;
        if (done_w[0] !== 1'b1 || addr_w[0] !== 10'd1023 || do_w[0] !== 16'hAAAA) begin
            errors++;
            $display("FAIL done_hold: got done=%b addr=%0d do=%h, expected done=1 addr=1023 do=aaaa",
                     done_w[0], addr_w[0], do_w[0]);
        end
        start_frame(0);
        run_frame(0, 1, 0, 16383, 0);
        checks++;
        if (img[0][0] !== 16'h0000 || img[0][1023] !== 16'h0000) begin
            errors++;
            $display("FAIL zero_frame: got word0=%h word1023=%h, expected 0000", img[0][0], img[0][1023]);
        end
    endtask

    task automatic test_gaps();
        for (int a = 0; a < 1024; a++) img[0][a] = 'x;
        start_frame(0);
        run_frame(0, 0, 50, 16383, 0);
        for (int a = 0; a < 1024; a++) begin
            checks++;
            if (img[0][a] !== ref_img[a]) begin
                errors++;
                $display("FAIL gap_image addr=%0d: got %h, expected %h", a, img[0][a], ref_img[a]);
            end
        end
    endtask

    task automatic test_threshold();
        logic [7:0] first [4];
        first[0] = 8'd128; first[1] = 8'd127; first[2] = 8'd0; first[3] = 8'd255;
        start_frame(1);
        for (int i = 0; i < 16; i++) begin
            send_pixel(1, (i < 4) ? first[i] : 8'd0, 1'b0, 0);
        end
        checks++;
        if (wr_w[1] !== 1'b1 || addr_w[1] !== 10'd0 || do_w[1] !== 16'h9000) begin
            errors++;
            $display("FAIL thresh_word: got wr=%b addr=%0d do=%h, expected wr=1 addr=0 do=9000",
                     wr_w[1], addr_w[1], do_w[1]);
        end
        run_frame(1, 2, 0, 255, 16);
    endtask

    task automatic test_err_early();
        start_frame(1);
        run_frame(1, 2, 0, 100, 0);
        checks++;
        if (err_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL err_early: got err=%b, expected 1", err_w[1]);
        end
    endtask

    task automatic test_err_missing();
        start_frame(1);
        run_frame(1, 2, 0, -1, 0);
        checks++;
        if (err_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL err_missing: got err=%b, expected 1", err_w[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(1);
        for (int i = 0; i < 40; i++) send_pixel(1, pix_val(2, i), 1'b0, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++;
        if (rdy_w[1] !== 1'b0 || wr_w[1] !== 1'b0 || addr_w[1] !== 10'd0 ||
            do_w[1] !== 16'd0 || done_w[1] !== 1'b0 || err_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: got ready=%b wr=%b addr=%0d do=%h done=%b err=%b, expected all 0",
                     rdy_w[1], wr_w[1], addr_w[1], do_w[1], done_w[1], err_w[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt[1] !== 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_writes: got %0d writes (%0d pending), expected 2", wr_cnt[1], exp_q.size());
        end
        for (int a = 0; a < 16; a++) img[1][a] = 'x;
        start_frame(1);
        run_frame(1, 2, 0, 255, 0);
        for (int a = 0; a < 16; a++) begin
            checks++;
            if ($isunknown(img[1][a])) begin
                errors++;
                $display("FAIL mid_reset_cover addr=%0d: got %h, expected a written word", a, img[1][a]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        start_v = 2'b00;
        valid_v = 2'b00;
        last_v = 2'b00;
        data_v[0] = 8'd0;
        data_v[1] = 8'd0;
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
        npix[0] = 16384;
        npix[1] = 256;
        thr[0] = 8'd0;
        thr[1] = 8'd127;
        m_bits = '0;
        m_cnt = 0;
        m_err = 1'b0;

        test_reset();
        test_full_frame();
        test_restart_from_done();
        test_gaps();
        test_threshold();
        test_err_early();
        test_err_missing();
        test_reset_mid_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
